// File: rtl/rf_pkg.sv
// Shared sizing constants and FSM state encoding for the register-file read controller.
package rf_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned WIDTH    = 16;
  localparam int unsigned REG_ID_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StResp
  } rf_state_e;

endpackage

// File: rtl/rf_wordline_decoder.sv
// Register ID to one-hot wordline decode; register 0 and disabled decode give all-zero.
module rf_wordline_decoder
  import rf_pkg::*;
#(
  parameter int unsigned NumRegs = NUM_REGS
) (
  input  logic                en_i,
  input  logic [REG_ID_W-1:0] id_i,
  output logic [NumRegs-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i && (id_i != '0) && (32'(id_i) < NumRegs)) begin
      onehot_o[id_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_read_ctrl.sv
// Two-port register-file read sequencer: accept request, pulse wordlines for one cycle,
// capture bitlines (with write bypass) and hold the response until it is taken.
module rf_read_ctrl #(
  parameter int unsigned NUM_REGS = rf_pkg::NUM_REGS,
  parameter int unsigned WIDTH    = rf_pkg::WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [rf_pkg::REG_ID_W-1:0] src1,
  input  logic [rf_pkg::REG_ID_W-1:0] src2,
  input  logic                        wr_en,
  input  logic [rf_pkg::REG_ID_W-1:0] wr_reg,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [NUM_REGS-1:0]         ReadEnable1,
  output logic [NUM_REGS-1:0]         ReadEnable2,
  input  logic [WIDTH-1:0]            Bitline1,
  input  logic [WIDTH-1:0]            Bitline2,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_data1,
  output logic [WIDTH-1:0]            rsp_data2
);

  import rf_pkg::*;

  rf_state_e             state_q, state_d;
  logic [REG_ID_W-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [NUM_REGS-1:0]   re1_q, re1_d, re2_q, re2_d;
  logic [WIDTH-1:0]      data1_q, data1_d, data2_q, data2_d;
  logic                  accept;

  // Register 0 is hardwired to zero and never takes a bypassed write.
  function automatic logic [WIDTH-1:0] port_data(input logic [REG_ID_W-1:0] id,
                                                 input logic [WIDTH-1:0]    bitline,
                                                 input logic                we,
                                                 input logic [REG_ID_W-1:0] wreg,
                                                 input logic [WIDTH-1:0]    wdata);
    if (id == '0) begin
      return '0;
    end else if (we && (wreg == id)) begin
      return wdata;
    end
    return bitline;
  endfunction

  always_comb begin
    req_ready = !rst && ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    accept    = req_valid && req_ready;
  end

  // Wordlines are decoded from the incoming IDs on acceptance so they are live in READ.
  rf_wordline_decoder #(
    .NumRegs (NUM_REGS)
  ) u_dec1 (
    .en_i     (accept),
    .id_i     (src1),
    .onehot_o (re1_d)
  );

  rf_wordline_decoder #(
    .NumRegs (NUM_REGS)
  ) u_dec2 (
    .en_i     (accept),
    .id_i     (src2),
    .onehot_o (re2_d)
  );

  always_comb begin
    state_d = state_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRead;
          src1_d  = src1;
          src2_d  = src2;
        end
      end
      StRead: begin
        state_d = StResp;
        data1_d = port_data(src1_q, Bitline1, wr_en, wr_reg, wr_data);
        data2_d = port_data(src2_q, Bitline2, wr_en, wr_reg, wr_data);
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = accept ? StRead : StIdle;
          if (accept) begin
            src1_d = src1;
            src2_d = src2;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      src1_q  <= '0;
      src2_q  <= '0;
      re1_q   <= '0;
      re2_q   <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      re1_q   <= re1_d;
      re2_q   <= re2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_comb begin
    ReadEnable1 = re1_q;
    ReadEnable2 = re2_q;
    rsp_valid   = (state_q == StResp);
    rsp_data1   = data1_q;
    rsp_data2   = data2_q;
  end

endmodule

// File: tb/tb_rf_read_ctrl.sv
// Randomized self-checking bench for rf_read_ctrl against a register-array reference model.
module tb_rf_read_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  src1, src2;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic [15:0] ReadEnable1, ReadEnable2;
  logic [15:0] Bitline1, Bitline2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data1, rsp_data2;

  logic [15:0] mem [16];
  int checks;
  int errors;

  rf_read_ctrl #(
    .NUM_REGS (16),
    .WIDTH    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .src1        (src1),
    .src2        (src2),
    .wr_en       (wr_en),
    .wr_reg      (wr_reg),
    .wr_data     (wr_data),
    .ReadEnable1 (ReadEnable1),
    .ReadEnable2 (ReadEnable2),
    .Bitline1    (Bitline1),
    .Bitline2    (Bitline2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data1   (rsp_data1),
    .rsp_data2   (rsp_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: an idle bitline floats to a nonzero pattern, so a zero result must come
  // from the controller rather than from the array.
  always_comb begin
    Bitline1 = 16'hDEAD;
    Bitline2 = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      if (ReadEnable1[i]) Bitline1 = mem[i];
      if (ReadEnable2[i]) Bitline2 = mem[i];
    end
  end

  function automatic logic [15:0] exp_wl(input logic [3:0] s);
    return (s == 4'd0) ? 16'h0000 : (16'h0001 << s);
  endfunction

  function automatic logic [15:0] exp_data(input logic [3:0] s, input logic we,
                                           input logic [3:0] wreg, input logic [15:0] wdat);
    if (s == 4'd0) return 16'h0000;
    if (we && wreg == s) return wdat;
    return mem[s];
  endfunction

  // Drives one request from IDLE and returns wordlines seen in READ and response seen in RESP.
  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic we,
                       input logic [3:0] wreg, input logic [15:0] wdat,
                       output logic [15:0] re1, output logic [15:0] re2, output logic rv,
                       output logic [15:0] d1, output logic [15:0] d2);
    req_valid = 1'b1;
    src1      = s1;
    src2      = s2;
    rsp_ready = 1'b0;
    @(negedge clk);
    re1       = ReadEnable1;
    re2       = ReadEnable2;
    req_valid = 1'b0;
    src1      = 4'($urandom);
    src2      = 4'($urandom);
    wr_en     = we;
    wr_reg    = wreg;
    wr_data   = wdat;
    @(negedge clk);
    rv        = rsp_valid;
    d1        = rsp_data1;
    d2        = rsp_data2;
    wr_en     = 1'b0;
    wr_reg    = 4'($urandom);
    wr_data   = 16'($urandom);
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data1 !== 16'h0 || rsp_data2 !== 16'h0) begin
      errors++; $display("FAIL rst_rsp got v=%b %h %h exp 0", rsp_valid, rsp_data1, rsp_data2);
    end
    checks++;
    if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0) begin
      errors++; $display("FAIL rst_wl got %h %h exp 0", ReadEnable1, ReadEnable2);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] re1, re2, d1, d2;
    logic rv;
    mem[3] = 16'h1234;
    mem[7] = 16'hBEEF;
    issue(4'd3, 4'd7, 1'b0, 4'd0, 16'h0, re1, re2, rv, d1, d2);
    checks++;
    if (re1 !== 16'h0008 || re2 !== 16'h0080) begin
      errors++; $display("FAIL dir_wl got %h %h exp 0008 0080", re1, re2);
    end
    checks++;
    if (rv !== 1'b1 || d1 !== 16'h1234 || d2 !== 16'hBEEF) begin
      errors++; $display("FAIL dir_rsp got v=%b %h %h exp 1 1234 beef", rv, d1, d2);
    end
    release_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || ReadEnable1 !== 16'h0) begin
      errors++; $display("FAIL dir_idle got v=%b wl=%h exp 0 0", rsp_valid, ReadEnable1);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] re1, re2, d1, d2;
    logic rv;
    issue(4'd3, 4'd7, 1'b1, 4'd3, 16'hA5A5, re1, re2, rv, d1, d2);
    checks++;
    if (d1 !== 16'hA5A5 || d2 !== 16'hBEEF) begin
      errors++; $display("FAIL byp_port1 got %h %h exp a5a5 beef", d1, d2);
    end
    release_rsp();
    issue(4'd7, 4'd7, 1'b1, 4'd7, 16'h5A5A, re1, re2, rv, d1, d2);
    checks++;
    if (re1 !== 16'h0080 || re2 !== 16'h0080 || d1 !== 16'h5A5A || d2 !== 16'h5A5A) begin
      errors++; $display("FAIL byp_same got %h %h %h %h exp 0080 0080 5a5a 5a5a",
                         re1, re2, d1, d2);
    end
    release_rsp();
  endtask

  task automatic test_zero();
    logic [15:0] re1, re2, d1, d2;
    logic rv;
    issue(4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, re1, re2, rv, d1, d2);
    checks++;
    if (re1 !== 16'h0 || re2 !== 16'h0 || d1 !== 16'h0 || d2 !== 16'h0) begin
      errors++; $display("FAIL zero_both got %h %h %h %h exp 0", re1, re2, d1, d2);
    end
    release_rsp();
    issue(4'd0, 4'd3, 1'b1, 4'd0, 16'hFFFF, re1, re2, rv, d1, d2);
    checks++;
    if (d1 !== 16'h0 || d2 !== 16'h1234) begin
      errors++; $display("FAIL zero_mixed got %h %h exp 0000 1234", d1, d2);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    logic [15:0] re1, re2, d1, d2;
    logic rv;
    issue(4'd3, 4'd7, 1'b0, 4'd0, 16'h0, re1, re2, rv, d1, d2);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      src1 = 4'd7;
      src2 = 4'd3;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data1 !== d1 || rsp_data2 !== d2 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b %h %h rdy=%b exp 1 %h %h 0",
                           i, rsp_valid, rsp_data1, rsp_data2, req_ready, d1, d2);
      end
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got %b exp 1", req_ready);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || ReadEnable1 !== 16'h0080 || ReadEnable2 !== 16'h0008) begin
      errors++; $display("FAIL bp_next_read got v=%b %h %h exp 0 0080 0008",
                         rsp_valid, ReadEnable1, ReadEnable2);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data1 !== 16'hBEEF || rsp_data2 !== 16'h1234) begin
      errors++; $display("FAIL bp_next_rsp got v=%b %h %h exp 1 beef 1234",
                         rsp_valid, rsp_data1, rsp_data2);
    end
    release_rsp();
  endtask

  task automatic test_reset_mid();
    logic [15:0] re1, re2, d1, d2;
    logic rv;
    logic seen;
    req_valid = 1'b1;
    src1 = 4'd5;
    src2 = 4'd2;
    @(negedge clk);
    checks++;
    if (ReadEnable1 !== 16'h0020) begin
      errors++; $display("FAIL rm_wl got %h exp 0020", ReadEnable1);
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ReadEnable1 !== 16'h0 || ReadEnable2 !== 16'h0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b0) begin
      errors++; $display("FAIL rm_abort got %h %h v=%b rdy=%b exp 0 0 0 0",
                         ReadEnable1, ReadEnable2, rsp_valid, req_ready);
    end
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL rm_no_rsp got %b exp 0", seen);
    end
    issue(4'd3, 4'd7, 1'b0, 4'd0, 16'h0, re1, re2, rv, d1, d2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data1 !== 16'h0 || rsp_data2 !== 16'h0) begin
      errors++; $display("FAIL rm_resp_abort got v=%b %h %h exp 0 0 0",
                         rsp_valid, rsp_data1, rsp_data2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  s1 [8];
    logic [3:0]  s2 [8];
    logic [15:0] e1 [$];
    logic [15:0] e2 [$];
    int n_acc, n_rsp, cyc, first_acc, last_rsp;
    for (int i = 1; i < 16; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      s1[i] = 4'($urandom);
      s2[i] = 4'($urandom);
    end
    n_acc = 0; n_rsp = 0; cyc = 0; first_acc = -1; last_rsp = -1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    src1 = s1[0];
    src2 = s2[0];
    while (n_rsp < 8 && cyc < 40) begin
      #1;
      if (rsp_valid) begin
        checks++;
        if (e1.size() == 0 || rsp_data1 !== e1[0] || rsp_data2 !== e2[0]) begin
          errors++; $display("FAIL b2b_data%0d got %h %h", n_rsp, rsp_data1, rsp_data2);
        end
        if (e1.size() != 0) begin
          void'(e1.pop_front());
          void'(e2.pop_front());
        end
        n_rsp++;
        last_rsp = cyc;
      end
      if (req_valid && req_ready) begin
        if (n_acc == 0) first_acc = cyc;
        e1.push_back(exp_data(s1[n_acc], 1'b0, 4'd0, 16'h0));
        e2.push_back(exp_data(s2[n_acc], 1'b0, 4'd0, 16'h0));
        n_acc++;
      end
      @(negedge clk);
      cyc++;
      req_valid = (n_acc < 8);
      if (n_acc < 8) begin
        src1 = s1[n_acc];
        src2 = s2[n_acc];
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (n_rsp !== 8 || (last_rsp - first_acc) !== 16) begin
      errors++; $display("FAIL b2b_rate got rsp=%0d span=%0d exp 8 16",
                         n_rsp, last_rsp - first_acc);
    end
  endtask

  task automatic test_random();
    logic [15:0] re1, re2, d1, d2, wdat;
    logic [3:0]  s1, s2, wreg;
    logic        we, rv;
    int          hold;
    for (int n = 0; n < 40; n++) begin
      mem[$urandom_range(1, 15)] = 16'($urandom);
      s1 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      s2 = ($urandom_range(0, 5) == 0) ? s1 : 4'($urandom);
      we = 1'($urandom);
      case ($urandom_range(0, 3))
        0: wreg = s1;
        1: wreg = s2;
        2: wreg = 4'd0;
        default: wreg = 4'($urandom);
      endcase
      wdat = 16'($urandom);
      issue(s1, s2, we, wreg, wdat, re1, re2, rv, d1, d2);
      checks++;
      if (re1 !== exp_wl(s1) || re2 !== exp_wl(s2)) begin
        errors++; $display("FAIL rnd_wl%0d got %h %h exp %h %h",
                           n, re1, re2, exp_wl(s1), exp_wl(s2));
      end
      checks++;
      if (rv !== 1'b1 || d1 !== exp_data(s1, we, wreg, wdat) ||
          d2 !== exp_data(s2, we, wreg, wdat)) begin
        errors++; $display("FAIL rnd_data%0d got v=%b %h %h exp 1 %h %h", n, rv, d1, d2,
                           exp_data(s1, we, wreg, wdat), exp_data(s2, we, wreg, wdat));
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        wr_en = 1'($urandom);
        wr_reg = 4'($urandom);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data1 !== d1 || rsp_data2 !== d2) begin
          errors++; $display("FAIL rnd_hold%0d got v=%b %h %h exp 1 %h %h",
                             n, rsp_valid, rsp_data1, rsp_data2, d1, d2);
        end
      end
      wr_en = 1'b0;
      release_rsp();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    src1      = 4'd0;
    src2      = 4'd0;
    wr_en     = 1'b0;
    wr_reg    = 4'd0;
    wr_data   = 16'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    test_reset();
    test_directed();
    test_bypass();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
